// File: rtl/store_narrow_pkg.sv
// Shared codes and widths for the store narrowing unit: size encodings,
// byte-enable constants and the width of a formatted lane record.
package store_narrow_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_ALL  = 4'b1111;

  // Formatted record without the address: {data[31:0], be[3:0], err, ovf}
  localparam int FMT_W = 32 + 4 + 1 + 1;

endpackage

// File: rtl/store_lane_format.sv
// Combinational store formatter: replicates rt into byte lanes and derives
// byte enables, alignment error and (with STORE_RANGE_CHECK_EN) overflow.
module store_lane_format
  import store_narrow_pkg::*;
(
  input  logic [31:0] rt,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  output logic [31:0] data,
  output logic [3:0]  be,
  output logic        err,
  output logic        ovf
);

  always_comb begin
    data = rt;
    be   = BE_NONE;
    err  = 1'b0;
    case (size)
      SZ_BYTE: begin
        data = {4{rt[7:0]}};
        be   = 4'b0001 << addr_lo;
      end
      SZ_HALF: begin
        data = {2{rt[15:0]}};
        be   = addr_lo[1] ? 4'b1100 : 4'b0011;
        err  = addr_lo[0];
      end
      SZ_WORD: begin
        be  = BE_ALL;
        err = (addr_lo != 2'b00);
      end
      default: err = 1'b1;
    endcase
    // Erroneous stores are still emitted, but must never touch memory.
    if (err) be = BE_NONE;
  end

`ifdef STORE_RANGE_CHECK_EN
  // A narrowing is lossless exactly when sign-extending the result restores rt.
  logic byte_ok, half_ok;
  assign byte_ok = (&rt[31:7])  || !(|rt[31:7]);
  assign half_ok = (&rt[31:15]) || !(|rt[31:15]);
  assign ovf = !err && (((size == SZ_BYTE) && !byte_ok) ||
                        ((size == SZ_HALF) && !half_ok));
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: formats requests at push and buffers them in a
// DEPTH-entry FIFO. Optional range check via STORE_RANGE_CHECK_EN.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds its fields stable while valid && !ready.
module store_narrow_unit
  import store_narrow_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_data,
  input  logic [1:0]        in_size,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic [3:0]        out_be,
  output logic              out_err,
  output logic              out_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [FMT_W-1:0]  mem_fmt  [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             push, pop;

  logic [31:0]       f_data;
  logic [3:0]        f_be;
  logic              f_err, f_ovf;
  logic [ADDR_W-1:0] new_addr, head_addr;
  logic [FMT_W-1:0]  new_fmt, head_fmt;

  store_lane_format u_fmt (
    .rt      (in_data),
    .addr_lo (in_addr[1:0]),
    .size    (in_size),
    .data    (f_data),
    .be      (f_be),
    .err     (f_err),
    .ovf     (f_ovf)
  );

  assign new_addr = {in_addr[ADDR_W-1:2], 2'b00};
  assign new_fmt  = {f_data, f_be, f_err, f_ovf};

  assign in_ready = (count != CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  always_comb begin
    rd_ptr_nxt = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_nxt  = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
    // The next head is the entry being written now when it lands in the head slot.
    if (push && (wr_ptr == rd_ptr_nxt)) begin
      head_addr = new_addr;
      head_fmt  = new_fmt;
    end else begin
      head_addr = mem_addr[rd_ptr_nxt];
      head_fmt  = mem_fmt[rd_ptr_nxt];
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= new_addr;
      mem_fmt[wr_ptr]  <= new_fmt;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_be    <= BE_NONE;
      out_err   <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
      // Output registers only reload when a head exists; otherwise they hold.
      if (count_nxt != '0) begin
        out_addr <= head_addr;
        {out_data, out_be, out_err, out_ovf} <= head_fmt;
      end
    end
  end

endmodule
